// File: rtl/wb_wbuf_if.sv
// Bus bundle for the posted-write buffer: CPU-side Wishbone slave signals and
// SRAM-controller-side Wishbone master signals.
interface wb_wbuf_if #(
    parameter int unsigned ADR_WIDTH = 32
);
    logic                 s_wb_stb_i;
    logic                 s_wb_cyc_i;
    logic                 s_wb_we_i;
    logic [ADR_WIDTH-1:0] s_wb_adr_i;
    logic [3:0]           s_wb_sel_i;
    logic [31:0]          s_wb_dat_i;
    logic [31:0]          s_wb_dat_o;
    logic                 s_wb_ack_o;

    logic                 m_wb_stb_o;
    logic                 m_wb_cyc_o;
    logic                 m_wb_we_o;
    logic [ADR_WIDTH-1:0] m_wb_adr_o;
    logic [3:0]           m_wb_sel_o;
    logic [31:0]          m_wb_dat_o;
    logic [31:0]          m_wb_dat_i;
    logic                 m_wb_ack_i;

    // Buffer's view: serves the CPU, masters the SRAM controller
    modport slave (
        input  s_wb_stb_i, s_wb_cyc_i, s_wb_we_i, s_wb_adr_i, s_wb_sel_i, s_wb_dat_i,
        output s_wb_dat_o, s_wb_ack_o,
        output m_wb_stb_o, m_wb_cyc_o, m_wb_we_o, m_wb_adr_o, m_wb_sel_o, m_wb_dat_o,
        input  m_wb_dat_i, m_wb_ack_i
    );

    // Environment's view: CPU master plus SRAM-controller slave
    modport master (
        output s_wb_stb_i, s_wb_cyc_i, s_wb_we_i, s_wb_adr_i, s_wb_sel_i, s_wb_dat_i,
        input  s_wb_dat_o, s_wb_ack_o,
        input  m_wb_stb_o, m_wb_cyc_o, m_wb_we_o, m_wb_adr_o, m_wb_sel_o, m_wb_dat_o,
        output m_wb_dat_i, m_wb_ack_i
    );
endinterface

// File: rtl/wb_wbuf.sv
// Posted-write buffer between the CPU Wishbone bus and the SRAM controller.
// Writes are acked immediately and drained in order; reads bypass only when the FIFO is empty.
module wb_wbuf #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADR_WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    wb_wbuf_if.slave  bus,
    output logic      wbuf_empty,
    output logic      wbuf_full
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ} m_state_e;

    m_state_e             state_q, state_d;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [ADR_WIDTH-1:0] fifo_adr [DEPTH];
    logic [3:0]           fifo_sel [DEPTH];
    logic [31:0]          fifo_dat [DEPTH];

    logic                 m_stb_q, m_stb_d;
    logic                 m_we_q, m_we_d;
    logic [ADR_WIDTH-1:0] m_adr_q, m_adr_d;
    logic [3:0]           m_sel_q, m_sel_d;
    logic [31:0]          m_dat_q, m_dat_d;
    logic                 s_ack_q, s_ack_d;
    logic [31:0]          s_dat_q, s_dat_d;
    logic                 rd_abort_q, rd_abort_d;

    logic                 req_valid, push, pop, fifo_full;

    assign req_valid = bus.s_wb_stb_i & bus.s_wb_cyc_i & ~s_ack_q;
    assign fifo_full = (count_q == CNT_W'(DEPTH));
    assign push      = req_valid & bus.s_wb_we_i & ~fifo_full;

    // Next-state and next-output logic for the downstream master
    always_comb begin
        state_d    = state_q;
        m_stb_d    = m_stb_q;
        m_we_d     = m_we_q;
        m_adr_d    = m_adr_q;
        m_sel_d    = m_sel_q;
        m_dat_d    = m_dat_q;
        s_dat_d    = s_dat_q;
        rd_abort_d = rd_abort_q;
        s_ack_d    = push;
        pop        = 1'b0;

        unique case (state_q)
            M_IDLE: begin
                if (count_q != '0) begin
                    state_d = M_WRITE;
                    m_stb_d = 1'b1;
                    m_we_d  = 1'b1;
                    m_adr_d = fifo_adr[rd_ptr_q];
                    m_sel_d = fifo_sel[rd_ptr_q];
                    m_dat_d = fifo_dat[rd_ptr_q];
                end else if (req_valid && !bus.s_wb_we_i) begin
                    state_d    = M_READ;
                    m_stb_d    = 1'b1;
                    m_we_d     = 1'b0;
                    m_adr_d    = bus.s_wb_adr_i;
                    m_sel_d    = bus.s_wb_sel_i;
                    rd_abort_d = 1'b0;
                end
            end
            M_WRITE: begin
                if (bus.m_wb_ack_i) begin
                    pop     = 1'b1;
                    m_stb_d = 1'b0;
                    state_d = M_IDLE;
                end
            end
            M_READ: begin
                // Once the requester abandons the cycle, the returning data is dropped
                rd_abort_d = rd_abort_q | ~bus.s_wb_cyc_i;
                if (bus.m_wb_ack_i) begin
                    m_stb_d = 1'b0;
                    state_d = M_IDLE;
                    if (!rd_abort_q && bus.s_wb_cyc_i && bus.s_wb_stb_i) begin
                        s_dat_d = bus.m_wb_dat_i;
                        s_ack_d = 1'b1;
                    end
                end
            end
            default: state_d = M_IDLE;
        endcase

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // State, pointers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= M_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            m_stb_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_adr_q    <= '0;
            m_sel_q    <= '0;
            m_dat_q    <= '0;
            s_ack_q    <= 1'b0;
            s_dat_q    <= '0;
            rd_abort_q <= 1'b0;
            wbuf_empty <= 1'b1;
            wbuf_full  <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q    <= count_d;
            m_stb_q    <= m_stb_d;
            m_we_q     <= m_we_d;
            m_adr_q    <= m_adr_d;
            m_sel_q    <= m_sel_d;
            m_dat_q    <= m_dat_d;
            s_ack_q    <= s_ack_d;
            s_dat_q    <= s_dat_d;
            rd_abort_q <= rd_abort_d;
            wbuf_empty <= (count_d == '0);
            wbuf_full  <= (count_d == CNT_W'(DEPTH));
        end
    end

    // Entry storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_adr[wr_ptr_q] <= bus.s_wb_adr_i;
            fifo_sel[wr_ptr_q] <= bus.s_wb_sel_i;
            fifo_dat[wr_ptr_q] <= bus.s_wb_dat_i;
        end
    end

    assign bus.m_wb_stb_o = m_stb_q;
    assign bus.m_wb_cyc_o = m_stb_q;
    assign bus.m_wb_we_o  = m_we_q;
    assign bus.m_wb_adr_o = m_adr_q;
    assign bus.m_wb_sel_o = m_sel_q;
    assign bus.m_wb_dat_o = m_dat_q;
    assign bus.s_wb_ack_o = s_ack_q;
    assign bus.s_wb_dat_o = s_dat_q;
endmodule

// File: tb/tb_wb_wbuf.sv
// Self-checking bench for wb_wbuf: vector table of single transactions plus
// hand sequences for stall, ordering, same-edge push/pop, read abort and reset.
module tb_wb_wbuf;
    logic clk = 1'b0;
    logic reset;
    logic wbuf_empty, wbuf_full;

    wb_wbuf_if #(.ADR_WIDTH(32)) bus ();

    wb_wbuf #(.DEPTH(4), .ADR_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .wbuf_empty (wbuf_empty),
        .wbuf_full  (wbuf_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          delay;
        int          exp_lat;
        logic [31:0] exp_rdat;
    } vec_t;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } sb_t;

    sb_t  sb_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   ack_en = 1'b1;
    int   ack_delay = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdata(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // Downstream SRAM-controller model: acks after ack_delay strobed cycles
    initial begin : responder
        int wait_cnt;
        sb_t e;
        wait_cnt = 0;
        bus.m_wb_ack_i = 1'b0;
        bus.m_wb_dat_i = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.m_wb_ack_i) begin
                bus.m_wb_ack_i = 1'b0;
                wait_cnt = 0;
            end else if (bus.m_wb_stb_o && ack_en && !reset) begin
                if (wait_cnt >= ack_delay) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("m_we",  32'(bus.m_wb_we_o),  32'(e.we));
                        chk("m_adr", bus.m_wb_adr_o,       e.adr);
                        chk("m_sel", 32'(bus.m_wb_sel_o), 32'(e.sel));
                        chk("m_cyc", 32'(bus.m_wb_cyc_o), 32'd1);
                        if (e.we) chk("m_dat", bus.m_wb_dat_o, e.dat);
                    end
                    bus.m_wb_ack_i = 1'b1;
                    bus.m_wb_dat_i = rdata(bus.m_wb_adr_o);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic up_idle();
        bus.s_wb_stb_i = 1'b0;
        bus.s_wb_cyc_i = 1'b0;
        bus.s_wb_we_i  = 1'b0;
    endtask

    task automatic up_drive(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat);
        sb_t e;
        bus.s_wb_stb_i = 1'b1;
        bus.s_wb_cyc_i = 1'b1;
        bus.s_wb_we_i  = we;
        bus.s_wb_adr_i = adr;
        bus.s_wb_sel_i = sel;
        bus.s_wb_dat_i = dat;
        e.we = we; e.adr = adr; e.sel = sel; e.dat = we ? dat : 32'h0;
        sb_q.push_back(e);
    endtask

    // One upstream request after an idle cycle; returns ack latency and read data
    task automatic up_req(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input int budget,
                          output int lat, output logic [31:0] rdat);
        @(posedge clk); #1;
        up_drive(we, adr, sel, dat);
        lat  = -1;
        rdat = '0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            if (bus.s_wb_ack_o) begin
                lat  = c;
                rdat = bus.s_wb_dat_o;
                break;
            end
        end
        up_idle();
        if (lat < 0) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (wbuf_empty && !bus.m_wb_stb_o) begin
                done = 1'b1;
                break;
            end
        end
        chk({name, "_drain"}, 32'(done), 32'd1);
        chk({name, "_sb_left"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t        vecs[6];
        int          lat;
        logic [31:0] rd;
        bit          saw;

        vecs[0] = '{1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 0, 1, 32'h0};
        vecs[1] = '{1'b1, 32'h0000_0004, 4'h3, 32'h1234_5678, 2, 1, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_0104, 4'hF, 32'h0,         0, 2, 32'h5A5A_5B5E};
        vecs[3] = '{1'b0, 32'h0000_2000, 4'hC, 32'h0,         3, 5, 32'h5A5A_7A5A};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 4'h1, 32'h0000_0000, 1, 1, 32'h0};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 4'h8, 32'h0,         1, 3, 32'hA5A5_A5A6};

        up_idle();
        bus.s_wb_adr_i = '0;
        bus.s_wb_sel_i = '0;
        bus.s_wb_dat_i = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_stb", 32'(bus.m_wb_stb_o), 32'd0);
        chk("rst_m_cyc", 32'(bus.m_wb_cyc_o), 32'd0);
        chk("rst_m_we",  32'(bus.m_wb_we_o),  32'd0);
        chk("rst_s_ack", 32'(bus.s_wb_ack_o), 32'd0);
        chk("rst_empty", 32'(wbuf_empty),     32'd1);
        chk("rst_full",  32'(wbuf_full),      32'd0);
        chk("rst_s_dat", bus.s_wb_dat_o,      32'd0);
        reset = 1'b0;

        // Single transactions from an empty buffer
        foreach (vecs[i]) begin
            ack_delay = vecs[i].delay;
            up_req(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, 50, lat, rd);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (!vecs[i].we) chk($sformatf("vec%0d_rdat", i), rd, vecs[i].exp_rdat);
            wait_drain($sformatf("vec%0d", i));
        end

        // Fill to full with downstream stalled; fifth write must wait for a pop
        ack_en = 1'b0;
        ack_delay = 0;
        for (int k = 0; k < 4; k++) begin
            up_req(1'b1, 32'h1000 + 32'(k * 4), 4'hF, 32'hA000_0000 + 32'(k), 10, lat, rd);
            chk($sformatf("fill%0d_lat", k), 32'(lat), 32'd1);
        end
        chk("fill_full", 32'(wbuf_full), 32'd1);
        @(posedge clk); #1;
        up_drive(1'b1, 32'h1010, 4'h5, 32'hA000_0004);
        saw = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus.s_wb_ack_o) saw = 1'b1;
        end
        chk("stall_no_ack", 32'(saw), 32'd0);
        chk("stall_full", 32'(wbuf_full), 32'd1);
        #2 ack_en = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.s_wb_ack_o) begin
                saw = 1'b1;
                break;
            end
        end
        up_idle();
        chk("stall_release_ack", 32'(saw), 32'd1);
        wait_drain("stall");

        // Two writes then a read: the read may only go out after both writes
        ack_delay = 2;
        up_req(1'b1, 32'h0000_0200, 4'hF, 32'h1111_2222, 10, lat, rd);
        up_req(1'b1, 32'h0000_0204, 4'h6, 32'h3333_4444, 10, lat, rd);
        up_req(1'b0, 32'h0000_0104, 4'hF, 32'h0, 60, lat, rd);
        chk("wr_rd_rdat", rd, 32'h5A5A_5B5E);
        wait_drain("wr_rd");

        // Same-edge push and pop at occupancy 2, pointers wrapping
        ack_en = 1'b0;
        ack_delay = 0;
        up_req(1'b1, 32'h0000_3000, 4'h1, 32'hC000_0000, 10, lat, rd);
        up_req(1'b1, 32'h0000_3004, 4'h2, 32'hC000_0001, 10, lat, rd);
        #2 ack_en = 1'b1;
        up_req(1'b1, 32'h0000_3008, 4'h4, 32'hC000_0002, 10, lat, rd);
        ack_en = 1'b0;
        chk("pp_lat", 32'(lat), 32'd1);
        chk("pp_not_full", 32'(wbuf_full), 32'd0);
        up_req(1'b1, 32'h0000_300C, 4'h8, 32'hC000_0003, 10, lat, rd);
        chk("pp_occ3_not_full", 32'(wbuf_full), 32'd0);
        up_req(1'b1, 32'h0000_3010, 4'hF, 32'hC000_0004, 10, lat, rd);
        chk("pp_occ4_full", 32'(wbuf_full), 32'd1);
        ack_en = 1'b1;
        wait_drain("pp");

        // Upstream abandons a read in flight: no ack, then a normal write
        ack_delay = 3;
        @(posedge clk); #1;
        up_drive(1'b0, 32'h0000_0300, 4'hF, 32'h0);
        @(posedge clk); #1;
        up_idle();
        saw = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus.s_wb_ack_o) saw = 1'b1;
        end
        chk("abort_no_ack", 32'(saw), 32'd0);
        chk("abort_rd_done", 32'(sb_q.size()), 32'd0);
        ack_delay = 0;
        up_req(1'b1, 32'h0000_0400, 4'hF, 32'h5555_AAAA, 10, lat, rd);
        chk("abort_next_wr_lat", 32'(lat), 32'd1);
        wait_drain("abort");

        // Reset while the master is writing with three entries buffered
        ack_en = 1'b0;
        for (int k = 0; k < 3; k++)
            up_req(1'b1, 32'h0000_4000 + 32'(k * 4), 4'hF, 32'hE000_0000 + 32'(k), 10, lat, rd);
        @(posedge clk); #1;
        chk("prerst_stb", 32'(bus.m_wb_stb_o), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_stb",   32'(bus.m_wb_stb_o), 32'd0);
        chk("midrst_cyc",   32'(bus.m_wb_cyc_o), 32'd0);
        chk("midrst_empty", 32'(wbuf_empty),     32'd1);
        chk("midrst_full",  32'(wbuf_full),      32'd0);
        chk("midrst_s_dat", bus.s_wb_dat_o,      32'd0);
        sb_q.delete();
        ack_en = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.m_wb_stb_o) saw = 1'b1;
        end
        chk("postrst_no_stb", 32'(saw), 32'd0);
        up_req(1'b1, 32'h0000_0500, 4'hF, 32'h0BAD_F00D, 10, lat, rd);
        chk("postrst_wr_lat", 32'(lat), 32'd1);
        wait_drain("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
